// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES key schedule (AES-128/192/256).
// Produces one 32-bit schedule word per clock and emits each 128-bit round key,
// in order 0..Nr, as soon as its four words have been generated.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous, active-high reset
//   start    - begin expansion (sampled only while idle)
//   key_in   - cipher key, w[0] in the top 32 bits
//   busy     - run in progress (through the done cycle)
//   rk_valid - one-cycle pulse qualifying rk/rk_idx
//   rk_idx   - round-key index 0..Nr
//   rk       - round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   done     - one-cycle pulse with the final round key
module aes_key_expand_seq #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [32*Nk-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    output logic [3:0]       rk_idx,
    output logic [127:0]     rk,
    output logic             done
);

    localparam logic [5:0] LastWord = 6'(4 * (Nr + 1) - 1);
    localparam logic [5:0] NkWords  = 6'(Nk);
    localparam logic [2:0] NkLast   = 3'(Nk - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              w_load;
    logic              w_run;
    logic              w_last;

    logic [32*Nk-1:0]  r_key;      // shifts left one word per run cycle
    logic [31:0]       r_win [Nk]; // w[i-Nk] at index 0 .. w[i-1] at index Nk-1
    logic [5:0]        r_i;
    logic [2:0]        r_mod;      // i mod Nk
    logic [7:0]        r_rcon;
    logic              r_rk_valid;
    logic [3:0]        r_rk_idx;
    logic [127:0]      r_rk;
    logic              r_done;

    logic [31:0]       w_prev;
    logic [31:0]       w_sub_in;
    logic [31:0]       w_sub;
    logic [31:0]       w_temp;
    logic [31:0]       w_word;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    assign w_last = (r_i == LastWord);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_run        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_run = 1'b1;
                if (w_last) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Word generation; the single SubWord instance is shared by both Sub cases.
    always_comb begin
        w_prev   = r_win[Nk-1];
        w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        for (int b = 0; b < 4; b++) begin
            w_sub[8*b +: 8] = sbox(w_sub_in[8*b +: 8]);
        end
        if (r_mod == 3'd0) begin
            w_temp = w_sub ^ {r_rcon, 24'h0};
        end else if (Nk == 8 && r_mod == 3'd4) begin
            w_temp = w_sub;
        end else begin
            w_temp = w_prev;
        end
        if (r_i < NkWords) w_word = r_key[32*Nk-1 -: 32];
        else               w_word = r_win[0] ^ w_temp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= '0;
            for (int k = 0; k < int'(Nk); k++) r_win[k] <= '0;
            r_i        <= '0;
            r_mod      <= '0;
            r_rcon     <= 8'h01;
            r_rk_valid <= 1'b0;
            r_rk_idx   <= '0;
            r_rk       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_load) begin
                r_key  <= key_in;
                r_i    <= '0;
                r_mod  <= '0;
                r_rcon <= 8'h01;
            end
            if (w_run) begin
                r_key <= {r_key[32*Nk-33:0], 32'h0};
                for (int k = 0; k < int'(Nk) - 1; k++) r_win[k] <= r_win[k+1];
                r_win[Nk-1] <= w_word;
                r_i         <= r_i + 6'd1;
                r_mod       <= (r_mod == NkLast) ? 3'd0 : r_mod + 3'd1;
                if (r_i >= NkWords && r_mod == 3'd0) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
                // Fourth word of a round key: the other three are the newest window entries.
                if (r_i[1:0] == 2'b11) begin
                    r_rk       <= {r_win[Nk-3], r_win[Nk-2], r_win[Nk-1], w_word};
                    r_rk_idx   <= r_i[5:2];
                    r_rk_valid <= 1'b1;
                    r_done     <= w_last;
                end
            end
        end
    end

    assign busy     = (r_state != StIdle);
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk       = r_rk;
    assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: one instance per key size, a scoreboard queue per
// instance filled from a FIPS-197 style reference schedule, and a monitor that
// pops and compares on every rk_valid pulse, including the edge it arrives on.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_s [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic         vld [3];
    logic         dn  [3];
    logic         bsy [3];
    logic [3:0]   idx [3];
    logic [127:0] rkv [3];

    always #5 clk = ~clk;

    aes_key_expand_seq #(.Nk(4), .Nr(10)) u_a128 (
        .clk(clk), .rst(rst), .start(start_s[0]), .key_in(key128), .busy(bsy[0]),
        .rk_valid(vld[0]), .rk_idx(idx[0]), .rk(rkv[0]), .done(dn[0])
    );
    aes_key_expand_seq #(.Nk(6), .Nr(12)) u_a192 (
        .clk(clk), .rst(rst), .start(start_s[1]), .key_in(key192), .busy(bsy[1]),
        .rk_valid(vld[1]), .rk_idx(idx[1]), .rk(rkv[1]), .done(dn[1])
    );
    aes_key_expand_seq #(.Nk(8), .Nr(14)) u_a256 (
        .clk(clk), .rst(rst), .start(start_s[2]), .key_in(key256), .busy(bsy[2]),
        .rk_valid(vld[2]), .rk_idx(idx[2]), .rk(rkv[2]), .done(dn[2])
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         last;
        logic [31:0]  at_cyc;
    } exp_t;

    exp_t         q0 [$];
    exp_t         q1 [$];
    exp_t         q2 [$];
    int unsigned  total = 0;
    int unsigned  bad = 0;
    int unsigned  cyc = 0;
    int unsigned  n_valid [3];
    int unsigned  n_done [3];
    int unsigned  exp_done [3];
    logic [127:0] got [3][16];
    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_tab [10];
    logic [31:0]  mw [60];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int c, input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cfg%0d %s: got %0h want %0h", c, name, act, exp);
        end
    endtask

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Reference schedule into mw[]; key is right-aligned, w[0] highest.
    task automatic expand(input int nk, input int nr, input logic [255:0] k);
        logic [31:0] t;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                mw[i] = k[32*(nk-1-i) +: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
                else if (nk == 8 && i % nk == 4) t = sub_word(t);
                mw[i] = mw[i-nk] ^ t;
            end
        end
    endtask

    function automatic int qsize(input int c);
        case (c)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpop(input int c, output exp_t e);
        case (c)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic push_exp(input int c, input logic [255:0] k, input int unsigned acc);
        int   nk;
        int   nr;
        exp_t e;
        nk = (c == 0) ? 4 : (c == 1) ? 6 : 8;
        nr = nk + 6;
        expand(nk, nr, k);
        for (int r = 0; r <= nr; r++) begin
            e.idx    = 4'(r);
            e.rk     = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
            e.last   = (r == nr);
            e.at_cyc = 32'(acc + 4 * (r + 1));
            case (c)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic set_key(input int c, input logic [255:0] k);
        case (c)
            0:       key128 = k[127:0];
            1:       key192 = k[191:0];
            default: key256 = k;
        endcase
    endtask

    // Called at a negedge; start is sampled on the next posedge (edge acc).
    task automatic do_start(input int c, input logic [255:0] k, output int unsigned acc);
        set_key(c, k);
        start_s[c] = 1'b1;
        acc = cyc + 1;
        exp_done[c]++;
        push_exp(c, k, acc);
        @(negedge clk);
        start_s[c] = 1'b0;
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    // Optional noise: random start pulses and key changes while busy must be ignored.
    task automatic wait_idle(input int c, input bit noise);
        int k;
        k = 0;
        while (bsy[c] && k < 200) begin
            if (noise) begin
                start_s[c] = ($urandom_range(0, 3) == 0);
                set_key(c, rand_key());
            end
            @(negedge clk);
            k++;
        end
        start_s[c] = 1'b0;
        check(c, "run_finishes", 256'(bsy[c]), 256'(0));
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            if (dn[c]) n_done[c]++;
            if (dn[c] && !vld[c]) check(c, "done_needs_valid", 256'(vld[c]), 256'(1));
            if (vld[c]) begin
                n_valid[c]++;
                got[c][idx[c]] = rkv[c];
                if (qsize(c) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cfg%0d unexpected_rk_valid: got idx %0d want no pulse",
                             c, idx[c]);
                end else begin
                    qpop(c, e);
                    check(c, "rk_idx", 256'(idx[c]), 256'(e.idx));
                    check(c, "rk", 256'(rkv[c]), 256'(e.rk));
                    check(c, "done_flag", 256'(dn[c]), 256'(e.last));
                    check(c, "rk_edge", 256'(cyc), 256'(e.at_cyc));
                    check(c, "busy_with_valid", 256'(bsy[c]), 256'(1));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1);
    end

    initial begin
        int unsigned  acc;
        int unsigned  acc2;
        int unsigned  nv;
        logic [255:0] k;

        build_sbox();
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int c = 0; c < 3; c++) begin
            start_s[c]  = 1'b0;
            n_valid[c]  = 0;
            n_done[c]   = 0;
            exp_done[c] = 0;
        end
        key128 = '0;
        key192 = '0;
        key256 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check(c, "reset_busy", 256'(bsy[c]), 256'(0));
            check(c, "reset_valid", 256'(vld[c]), 256'(0));
            check(c, "reset_done", 256'(dn[c]), 256'(0));
            check(c, "reset_idx", 256'(idx[c]), 256'(0));
            check(c, "reset_rk", 256'(rkv[c]), 256'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        // AES-128 known key, with starts during the run and on the done cycle.
        nv = n_valid[0];
        do_start(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, acc);
        wait_until(acc + 10);
        k = rand_key();
        set_key(0, k);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_until(acc + 44);
        check(0, "done_at_44", 256'(dn[0]), 256'(1));
        check(0, "busy_at_done", 256'(bsy[0]), 256'(1));
        k = rand_key();
        set_key(0, k);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        check(0, "idle_after_done", 256'(bsy[0]), 256'(0));
        check(0, "valid_low_after_done", 256'(vld[0]), 256'(0));
        check(0, "done_low_after_done", 256'(dn[0]), 256'(0));
        check(0, "rk_hold", 256'(rkv[0]), 256'h d014f9a8c9ee2589e13f0cc8b6630ca6);
        check(0, "idx_hold", 256'(idx[0]), 256'(10));
        check(0, "rk0_is_key", 256'(got[0][0]), 256'h2b7e151628aed2a6abf7158809cf4f3c);
        check(0, "rk1_known", 256'(got[0][1]), 256'ha0fafe1788542cb123a339392a6c7605);
        check(0, "rk10_known", 256'(got[0][10]), 256'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check(0, "pulses_128", 256'(n_valid[0] - nv), 256'(11));

        // Back-to-back start on the cycle after done.
        do_start(0, 256'h000102030405060708090a0b0c0d0e0f, acc2);
        check(0, "restart_edge", 256'(acc2), 256'(acc + 46));
        wait_idle(0, 1'b0);
        check(0, "b2b_rk10", 256'(got[0][10]), 256'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset in the middle of a run.
        nv = n_valid[0];
        do_start(0, rand_key(), acc);
        wait_until(acc + 19);
        rst = 1'b1;
        q0.delete();
        exp_done[0]--;
        @(negedge clk);
        check(0, "abort_busy", 256'(bsy[0]), 256'(0));
        check(0, "abort_valid", 256'(vld[0]), 256'(0));
        check(0, "abort_rk", 256'(rkv[0]), 256'(0));
        check(0, "abort_idx", 256'(idx[0]), 256'(0));
        rst = 1'b0;
        check(0, "pulses_before_abort", 256'(n_valid[0] - nv), 256'(4));
        do_start(0, rand_key(), acc);
        wait_idle(0, 1'b1);

        // AES-192 known key.
        nv = n_valid[1];
        do_start(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, acc);
        wait_idle(1, 1'b0);
        check(1, "pulses_192", 256'(n_valid[1] - nv), 256'(13));

        // AES-256 known key.
        nv = n_valid[2];
        do_start(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, acc);
        wait_idle(2, 1'b0);
        check(2, "rk2_known", 256'(got[2][2]), 256'h9ba354118e6925afa51a8b5f2067fcde);
        check(2, "pulses_256", 256'(n_valid[2] - nv), 256'(15));

        // Random keys on every size, with ignored start/key noise while busy.
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 3; c++) begin
                do_start(c, rand_key(), acc);
                wait_idle(c, 1'b1);
            end
        end

        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check(c, "scoreboard_drained", 256'(qsize(c)), 256'(0));
            check(c, "done_count", 256'(n_done[c]), 256'(exp_done[c]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
